// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares one dmem syncram port between the processor load/store
//            path (port 0) and a secondary master (port 1). Grants one access
//            per cycle, drives dmem from the winner and routes read data back
//            to the requester that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int RR_MODE      = 0,
    parameter int MAX_WAIT     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    // Tag pipeline holds one stage per edge between grant and q_dmem valid.
    localparam int       c_PIPE_D   = READ_LATENCY + 1;
    localparam logic     c_RR       = (RR_MODE != 0);
    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    logic                r_last;       // last granted port (RR pointer)
    logic [7:0]          r_wait_cnt;   // consecutive denied cycles of port 1
    logic [c_PIPE_D-1:0] r_tag_v;      // read in flight at this stage
    logic [c_PIPE_D-1:0] r_tag_p;      // port id of that read
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_pick1;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_any;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    // Winner selection: tie-break is RR pointer or starvation counter
    always_comb begin
        w_pick1  = c_RR ? ~r_last : (r_wait_cnt == c_MAX_WAIT);
        w_grant1 = req1 & (~req0 | w_pick1);
        w_grant0 = req0 & ~w_grant1;
        w_any    = w_grant0 | w_grant1;
        w_we     = w_grant1 ? we1    : we0;
        w_addr   = w_grant1 ? addr1  : addr0;
        w_wdata  = w_grant1 ? wdata1 : wdata0;
    end

    // Registered grant and dmem drive; address/data hold while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            wren         <= 1'b0;
            address_dmem <= '0;
            data         <= '0;
        end else begin
            gnt0 <= w_grant0;
            gnt1 <= w_grant1;
            wren <= w_any & w_we;
            if (w_any) begin
                address_dmem <= w_addr;
                data         <= w_wdata;
            end
        end
    end

    // RR pointer moves only on a grant; wait counter tracks port 1 starvation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_any) begin
                r_last <= w_grant1;
            end
            if (req1 && !w_grant1) begin
                if (r_wait_cnt != c_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Read tags shift toward the stage aligned with q_dmem valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v <= {r_tag_v[c_PIPE_D-2:0], w_any & ~w_we};
            r_tag_p <= {r_tag_p[c_PIPE_D-2:0], w_grant1};
        end
    end

    assign rvalid0 = r_tag_v[READ_LATENCY] & ~r_tag_p[READ_LATENCY];
    assign rvalid1 = r_tag_v[READ_LATENCY] &  r_tag_p[READ_LATENCY];

    // Capture returned data so rdata holds its last valid value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (rvalid0) begin
                r_rdata0 <= q_dmem;
            end
            if (rvalid1) begin
                r_rdata1 <= q_dmem;
            end
        end
    end

    assign rdata0 = rvalid0 ? q_dmem : r_rdata0;
    assign rdata1 = rvalid1 ? q_dmem : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed bench for dmem_port_arbiter. Instance A runs fixed
//            priority with MAX_WAIT=3, instance B runs round-robin; each is
//            backed by a one-cycle-latency syncram model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- instance A: fixed priority ----------------
    logic        a_req0, a_we0, a_gnt0, a_rvalid0;
    logic [11:0] a_addr0;
    logic [31:0] a_wdata0, a_rdata0;
    logic        a_req1, a_we1, a_gnt1, a_rvalid1;
    logic [11:0] a_addr1;
    logic [31:0] a_wdata1, a_rdata1;
    logic [11:0] a_address_dmem;
    logic [31:0] a_data, a_q;
    logic        a_wren;
    logic [31:0] mem_a [0:4095];

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1),
                        .RR_MODE(0), .MAX_WAIT(3)) u_dut_a (
        .clock(clock), .reset(reset),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
        .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
        .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
        .address_dmem(a_address_dmem), .data(a_data), .wren(a_wren),
        .q_dmem(a_q)
    );

    always @(posedge clock) begin
        if (a_wren) mem_a[a_address_dmem] <= a_data;
        a_q <= mem_a[a_address_dmem];
    end

    // ---------------- instance B: round-robin ----------------
    logic        b_req0, b_we0, b_gnt0, b_rvalid0;
    logic [11:0] b_addr0;
    logic [31:0] b_wdata0, b_rdata0;
    logic        b_req1, b_we1, b_gnt1, b_rvalid1;
    logic [11:0] b_addr1;
    logic [31:0] b_wdata1, b_rdata1;
    logic [11:0] b_address_dmem;
    logic [31:0] b_data, b_q;
    logic        b_wren;
    logic [31:0] mem_b [0:4095];

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1),
                        .RR_MODE(1), .MAX_WAIT(3)) u_dut_b (
        .clock(clock), .reset(reset),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .address_dmem(b_address_dmem), .data(b_data), .wren(b_wren),
        .q_dmem(b_q)
    );

    always @(posedge clock) begin
        if (b_wren) mem_b[b_address_dmem] <= b_data;
        b_q <= mem_b[b_address_dmem];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [7:0] g0, g1;
    int         bad;

    initial begin
        mem_a[12'h020] <= 32'hDEADBEEF;
        mem_b[12'h100] <= 32'hA0000100;
        mem_b[12'h101] <= 32'hA0000101;

        reset = 1'b1;
        a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
        a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0;
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
        repeat (2) @(negedge clock);

        // reset state
        check("rst_gnt0",   {31'd0, a_gnt0},    32'd0);
        check("rst_gnt1",   {31'd0, a_gnt1},    32'd0);
        check("rst_rvalid", {30'd0, a_rvalid0, a_rvalid1}, 32'd0);
        check("rst_wren",   {31'd0, a_wren},    32'd0);
        check("rst_addr",   {20'd0, a_address_dmem}, 32'd0);
        check("rst_data",   a_data,             32'd0);
        reset = 1'b0;

        // reset mid-read: grant seen, then reset kills the in-flight read
        @(negedge clock);
        a_req0 = 1; a_we0 = 0; a_addr0 = 12'h010;
        @(negedge clock);
        check("midrd_gnt0", {31'd0, a_gnt0}, 32'd1);
        check("midrd_addr", {20'd0, a_address_dmem}, 32'h010);
        a_req0 = 0;
        reset  = 1'b1;
        #1;
        check("midrd_rst_gnt0", {31'd0, a_gnt0}, 32'd0);
        check("midrd_rst_addr", {20'd0, a_address_dmem}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (a_rvalid0 || a_rvalid1) bad++;
        end
        check("midrd_no_rvalid", bad, 0);

        // single read of 0x020 by port 0
        a_req0 = 1; a_we0 = 0; a_addr0 = 12'h020;
        @(negedge clock);
        check("rd_gnt0",    {31'd0, a_gnt0}, 32'd1);
        check("rd_gnt1",    {31'd0, a_gnt1}, 32'd0);
        check("rd_addr",    {20'd0, a_address_dmem}, 32'h020);
        check("rd_wren",    {31'd0, a_wren}, 32'd0);
        check("rd_early_rv",{31'd0, a_rvalid0}, 32'd0);
        a_req0 = 0;
        @(negedge clock);
        check("rd_rvalid0", {31'd0, a_rvalid0}, 32'd1);
        check("rd_rdata0",  a_rdata0, 32'hDEADBEEF);
        check("rd_rvalid1", {31'd0, a_rvalid1}, 32'd0);
        @(negedge clock);
        check("rd_rvalid0_off", {31'd0, a_rvalid0}, 32'd0);
        check("rd_rdata0_hold", a_rdata0, 32'hDEADBEEF);

        // port 1 write then read of 0x0FF
        a_req1 = 1; a_we1 = 1; a_addr1 = 12'h0FF; a_wdata1 = 32'h12345678;
        @(negedge clock);
        check("wr_gnt1", {31'd0, a_gnt1}, 32'd1);
        check("wr_wren", {31'd0, a_wren}, 32'd1);
        check("wr_data", a_data, 32'h12345678);
        check("wr_addr", {20'd0, a_address_dmem}, 32'h0FF);
        a_we1 = 0;
        @(negedge clock);
        check("wr_rd_gnt1", {31'd0, a_gnt1}, 32'd1);
        check("wr_rd_wren", {31'd0, a_wren}, 32'd0);
        check("wr_no_rvalid", {30'd0, a_rvalid0, a_rvalid1}, 32'd0);
        a_req1 = 0;
        @(negedge clock);
        check("wr_rd_rvalid1", {31'd0, a_rvalid1}, 32'd1);
        check("wr_rd_rdata1",  a_rdata1, 32'h12345678);
        check("wr_rd_rvalid0", {31'd0, a_rvalid0}, 32'd0);
        repeat (2) @(negedge clock);

        // fixed priority with starvation relief (MAX_WAIT=3)
        a_req0 = 1; a_we0 = 0; a_addr0 = 12'h001;
        a_req1 = 1; a_we1 = 0; a_addr1 = 12'h002;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            g0[i] = a_gnt0;
            g1[i] = a_gnt1;
            if (a_gnt0 && a_gnt1) bad++;
            if (a_rvalid0 && a_rvalid1) bad++;
        end
        check("fix_gnt0_seq", {24'd0, g0}, 32'h77);
        check("fix_gnt1_seq", {24'd0, g1}, 32'h88);
        check("fix_exclusive", bad, 0);
        a_req0 = 0; a_req1 = 0;
        repeat (3) @(negedge clock);

        // idle after a write to 0x055
        a_req0 = 1; a_we0 = 1; a_addr0 = 12'h055; a_wdata0 = 32'hCAFE0055;
        @(negedge clock);
        check("idle_wr_wren", {31'd0, a_wren}, 32'd1);
        a_req0 = 0; a_we0 = 0;
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (a_wren || a_gnt0 || a_gnt1 || a_rvalid0 || a_rvalid1) bad++;
            if (a_address_dmem != 12'h055) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_addr_hold", {20'd0, a_address_dmem}, 32'h055);
        check("idle_data_hold", a_data, 32'hCAFE0055);

        // round-robin: both ports reading continuously
        b_req0 = 1; b_we0 = 0; b_addr0 = 12'h100;
        b_req1 = 1; b_we1 = 0; b_addr1 = 12'h101;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i < 8) begin
                g0[i] = b_gnt0;
                g1[i] = b_gnt1;
            end
            if (i == 0) begin
                if (b_rvalid0 || b_rvalid1) bad++;
            end else if (i % 2 == 1) begin
                if (!b_rvalid1 || b_rvalid0 || b_rdata1 != 32'hA0000101) bad++;
            end else begin
                if (!b_rvalid0 || b_rvalid1 || b_rdata0 != 32'hA0000100) bad++;
            end
        end
        check("rr_gnt1_seq", {24'd0, g1}, 32'h55);
        check("rr_gnt0_seq", {24'd0, g0}, 32'hAA);
        check("rr_rvalid_tags", bad, 0);
        b_req0 = 0; b_req1 = 0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single dmem syncram port between two requesters: port 0 is the processor load/store path and port 1 is a secondary master such as a debug or loader engine. The block grants one access per cycle, drives dmem address/data/wren from the winner and routes q_dmem back to the requester that issued the read. It sits between the processor and dmem in the top level and runs on dmem_clock.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
READ_LATENCY, 1, edges from dmem sampling address to q_dmem valid (1..4)
RR_MODE, 0, 0 = fixed priority to port 0; 1 = round-robin
MAX_WAIT, 8, fixed mode only: consecutive denied cycles of port 1 before it is forced (1..255)

Ports:
clock  in  1  dmem-domain clock, rising edge
reset  in  1  asynchronous, active-high
req0  in  1  port 0 request; hold with we0/addr0/wdata0 stable until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 request accepted (1-cycle pulse)
rvalid0  out  1  port 0 read data valid (1-cycle pulse)
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  as port 0, for port 1
address_dmem  out  ADDR_W  to dmem address
data  out  DATA_W  to dmem data
wren  out  1  to dmem write enable
q_dmem  in  DATA_W  from dmem q

Behaviour:
- Reset (asynchronous, any time): gnt0/1=0, rvalid0/1=0, wren=0, address_dmem=0, data=0, RR pointer=port 0, wait counter=0, read-tag pipeline cleared. In-flight reads are discarded and never signal rvalid.
- Arbitration is evaluated at each rising edge E0 from the sampled req0/req1:
  - Neither requesting: no grant, wren=0, address_dmem and data hold their last values.
  - One requesting: that port wins.
  - Both, RR_MODE=0: port 0 wins unless wait_cnt==MAX_WAIT, in which case port 1 wins.
  - Both, RR_MODE=1: the port opposite the last winner wins. The pointer updates only on a grant.
- wait_cnt (fixed mode): increments when req1=1 and port 1 loses, saturates at MAX_WAIT, and clears when port 1 is granted or req1=0.
- Grant outputs, all registered and valid in the cycle after E0: gnt_winner=1 for exactly one cycle; address_dmem/data/wren take the winner's addr/wdata/we.
- Back-to-back operation: one access per cycle, no bubbles. A port holding req high after gnt is re-arbitrated as a new request.
- dmem samples address at E1, the edge after E0.
- Writes: wren is high only in the grant cycle. Writes never produce rvalid.
- Reads: a (port id, valid) tag enters a READ_LATENCY+1-deep shift pipeline at E0. rvalid_port is high in the cycle q_dmem is valid, i.e. the cycle after edge E0+1+READ_LATENCY−1. With READ_LATENCY=1 that is the cycle after E1, two cycles after the request was sampled. During that cycle rdata_port=q_dmem. At all other times rdata0/rdata1 hold their last valid value (registered capture).
- Read responses return in grant order. rvalid0 and rvalid1 are never high in the same cycle.
- req dropped before grant: the request is withdrawn, no side effects.
- Requester protocol violation (signals changed before gnt): the arbiter uses the value sampled at the winning edge. Not otherwise checked.

Test Plan:
- Reset mid-read: port 0 read addr 0x010 granted, assert reset one cycle later -> all outputs 0, no rvalid0 ever seen for that read.
- Single read (READ_LATENCY=1, mem[0x020]=0xDEADBEEF): req0 read 0x020 at E0 -> gnt0 in the cycle after E0, address_dmem=0x020, wren=0; rvalid0=1 with rdata0=0xDEADBEEF two cycles after E0, rvalid1 stays 0.
- Write then read: port 1 writes 0x12345678 to 0x0FF, then reads 0x0FF on the next cycle -> wren=1 for exactly one cycle, then rvalid1 with rdata1=0x12345678.
- Fixed priority with starvation, MAX_WAIT=3: req0 and req1 held high continuously -> grant order 0,0,0,1,0,0,0,1,...; gnt0 and gnt1 never high together.
- Round-robin (RR_MODE=1), both ports reading continuously with distinct addresses -> grants alternate 1,0,1,0 (pointer starts at port 0, so port 1 wins first); every rvalid is tagged to the correct port with the correct data, one per cycle, no bubbles.
- Idle: no requests for 10 cycles after a write to 0x055 -> wren=0, address_dmem holds 0x055, gnt and rvalid stay 0.
